cpu_transmissor: RTL and testbench

- CPU-side initiator of the four-phase send/ack handshake that feeds PERIFERICO's in_per_dados port.
- Accepts a 4-bit word from the CPU through a valid/ready port and drives per_send and out_per_dados.
- per_ack is generated in the peripheral clock domain, so it is resynchronised here before use.
- Runs on cpu_clk; also provides a timeout/error flag and a completed-transfer counter.

---
 rtl/cpu_transmissor.sv | 119 +++++++++++
 tb/tb_cpu_transmissor.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_transmissor.sv
// CPU-side initiator of the four-phase send/ack handshake toward the peripheral.
// Resynchronises per_ack, supervises the request with a timeout and counts completed transfers.
module cpu_transmissor #(
  parameter int DATA_W  = 4,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              cpu_valid,
  input  logic [DATA_W-1:0] cpu_dados,
  output logic              cpu_ready,
  output logic              per_send,
  output logic [DATA_W-1:0] out_per_dados,
  input  logic              per_ack,
  output logic              tx_done,
  output logic              tx_err,
  output logic [CNT_W-1:0]  tx_count
);

  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = (TIMEOUT > 0) ? TMO_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_LOW
  } state_t;

  state_t             state_reg, state_next;
  logic               send_reg, send_next;
  logic [DATA_W-1:0]  data_reg, data_next;
  logic               done_reg, done_next;
  logic               err_reg, err_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic [TMO_W-1:0]   tmo_reg, tmo_next;
  logic               abort_reg, abort_next;
  logic               ack_s1_reg, ack_s_reg;

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_reg  <= IDLE;
      send_reg   <= 1'b0;
      data_reg   <= '0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
      count_reg  <= '0;
      tmo_reg    <= '0;
      abort_reg  <= 1'b0;
      ack_s1_reg <= 1'b0;
      ack_s_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      send_reg   <= send_next;
      data_reg   <= data_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
      count_reg  <= count_next;
      tmo_reg    <= tmo_next;
      abort_reg  <= abort_next;
      ack_s1_reg <= per_ack;
      ack_s_reg  <= ack_s1_reg;
    end
  end

  always_comb begin
    state_next = state_reg;
    send_next  = send_reg;
    data_next  = data_reg;
    done_next  = 1'b0;
    err_next   = err_reg;
    count_next = count_reg;
    tmo_next   = tmo_reg;
    abort_next = abort_reg;
    case (state_reg)
      IDLE: begin
        if (cpu_valid) begin
          data_next  = cpu_dados;
          send_next  = 1'b1;
          tmo_next   = '0;
          abort_next = 1'b0;
          state_next = SEND;
        end
      end
      SEND: begin
        // An ack arriving on the expiry cycle still counts as success.
        if (ack_s_reg) begin
          send_next  = 1'b0;
          state_next = WAIT_LOW;
        end else if (TIMEOUT != 0 && tmo_reg == TMO_LAST) begin
          send_next  = 1'b0;
          err_next   = 1'b1;
          abort_next = 1'b1;
          state_next = WAIT_LOW;
        end else begin
          tmo_next = tmo_reg + 1'b1;
        end
      end
      WAIT_LOW: begin
        if (!ack_s_reg) begin
          state_next = IDLE;
          if (!abort_reg) begin
            done_next  = 1'b1;
            count_next = count_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign cpu_ready     = (state_reg == IDLE) && !cpu_rst;
  assign per_send      = send_reg;
  assign out_per_dados = data_reg;
  assign tx_done       = done_reg;
  assign tx_err        = err_reg;
  assign tx_count      = count_reg;

endmodule

// File: tb/tb_cpu_transmissor.sv
// Scoreboard bench for cpu_transmissor with a simple four-phase peripheral model.
module tb_cpu_transmissor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic [3:0] dados = 4'h0;
  logic       ready, send, ack, done, err;
  logic [3:0] pdata;
  logic [1:0] cnt;

  int checks = 0;
  int failures = 0;

  // 0: peripheral acks 3 cycles after send rises; 1: ack stuck low; 2: ack driven by main
  int   mode = 0;
  logic man_ack = 1'b0;
  logic auto_ack = 1'b0;
  bit   width_en = 1'b1;
  assign ack = (mode == 2) ? man_ack : auto_ack;

  logic [5:0] done_q[$];   // {data, count}
  int         width_q[$];

  always #5 clk = ~clk;

  cpu_transmissor #(.DATA_W(4), .TIMEOUT(8), .CNT_W(2)) dut (
    .cpu_clk(clk),
    .cpu_rst(rst),
    .cpu_valid(valid),
    .cpu_dados(dados),
    .cpu_ready(ready),
    .per_send(send),
    .out_per_dados(pdata),
    .per_ack(ack),
    .tx_done(done),
    .tx_err(err),
    .tx_count(cnt)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor + peripheral model, sampled on the falling edge
  logic       ps_prev = 1'b0;
  int         hi = 0;
  logic [3:0] cap = 4'h0;
  bit         changed = 1'b0;
  bit         rdy_bad = 1'b0;

  always @(negedge clk) begin
    logic [5:0] e;
    if (send && !ps_prev) begin
      cap = pdata; hi = 1; changed = 1'b0; rdy_bad = ready;
    end else if (send) begin
      hi++;
      if (pdata != cap) changed = 1'b1;
      if (ready) rdy_bad = 1'b1;
    end else if (ps_prev && width_en) begin
      if (width_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_send_pulse: got width %0d expected none", hi);
      end else begin
        chk("send_width", hi, width_q.pop_front());
      end
    end
    ps_prev = send;
    auto_ack = (mode == 0) && send && (hi >= 3);
    if (done) begin
      if (done_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_tx_done: got data=%h count=%0d expected no pulse", cap, cnt);
      end else begin
        e = done_q.pop_front();
        $display("tx data=%h count=%0d", cap, cnt);
        chk("tx_data", int'(cap), int'(e[5:2]));
        chk("tx_count", int'(cnt), int'(e[1:0]));
        chk("data_stable", int'(changed), 0);
        chk("ready_low_in_transfer", int'(rdy_bad), 0);
      end
    end
  end

  task automatic send_word(input logic [3:0] d);
    bit accepted = 1'b0;
    for (int i = 0; i < 60 && !accepted; i++) begin
      @(negedge clk);
      dados = d;
      valid = 1'b1;
      if (ready) begin
        @(posedge clk);
        #1;
        accepted = 1'b1;
      end
    end
    chk("accept_timeout", int'(accepted), 1);
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (done_q.size() == 0 && width_q.size() == 0 && ready && !send) ok = 1'b1;
    end
    chk("drain_timeout", int'(ok), 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("rst_per_send", int'(send), 0);
    chk("rst_data", int'(pdata), 0);
    chk("rst_ready", int'(ready), 1);
    chk("rst_count", int'(cnt), 0);
    chk("rst_err", int'(err), 0);

    // Single transfer
    width_q.push_back(5); done_q.push_back({4'hF, 2'd1});
    send_word(4'hF); valid = 1'b0;
    drain();

    // Back-to-back with cpu_valid held
    width_q.push_back(5); done_q.push_back({4'h3, 2'd2});
    width_q.push_back(5); done_q.push_back({4'hA, 2'd3});
    send_word(4'h3); send_word(4'hA); valid = 1'b0;
    drain();
    chk("b2b_count", int'(cnt), 3);

    // Timeout: ack stuck low
    mode = 1;
    width_q.push_back(8);
    send_word(4'h6); valid = 1'b0;
    drain();
    chk("timeout_err", int'(err), 1);
    chk("timeout_count", int'(cnt), 3);
    chk("timeout_ready", int'(ready), 1);

    // Successful transfer after timeout; error stays set
    mode = 0;
    width_q.push_back(5); done_q.push_back({4'h7, 2'd0});
    send_word(4'h7); valid = 1'b0;
    drain();
    chk("err_sticky", int'(err), 1);

    // Reset mid-transfer with ack high
    mode = 2; man_ack = 1'b0; width_en = 1'b0;
    send_word(4'h9); valid = 1'b0;
    @(negedge clk);
    chk("mid_send_high", int'(send), 1);
    man_ack = 1'b1; rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_send", int'(send), 0);
    chk("mid_rst_ready", int'(ready), 0);
    chk("mid_rst_count", int'(cnt), 0);
    chk("mid_rst_err", int'(err), 0);
    chk("mid_rst_data", int'(pdata), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_idle_ready", int'(ready), 1);
    man_ack = 1'b0; mode = 0; width_en = 1'b1;
    repeat (3) @(negedge clk);
    width_q.push_back(5); done_q.push_back({4'h5, 2'd1});
    send_word(4'h5); valid = 1'b0;
    drain();

    // Counter wrap, 2-bit counter
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("wrap_start_count", int'(cnt), 0);
    for (int i = 1; i <= 5; i++) begin
      width_q.push_back(5);
      done_q.push_back({4'(i), 2'(i)});
    end
    for (int i = 1; i <= 5; i++) send_word(4'(i));
    valid = 1'b0;
    drain();
    chk("wrap_final_count", int'(cnt), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
